// File: rtl/axis_width_downsizer_pkg.sv
// Shared definitions for the AXI-Stream width downsizer: bus-width defaults,
// FSM state encoding and the counter-width helper.
package axis_width_downsizer_pkg;

    localparam int unsigned BITS_PER_WORD = 8;
    localparam int unsigned W_Y_OUT       = 32;
    localparam int unsigned R             = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Minimum one bit even when only a single value needs encoding
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_width_downsizer.sv
// Splits one W_IN-bit AXI-Stream word into W_IN/W_OUT narrower beats with TLAST on
// the final beat; accepts the next word in the last-beat cycle so words stream without gaps.
module axis_width_downsizer
    import axis_width_downsizer_pkg::*;
#(
    parameter int unsigned W_IN      = R * W_Y_OUT,
    parameter int unsigned W_OUT     = BITS_PER_WORD,
    parameter logic        LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    output logic             s_axis_tready,
    input  logic             s_axis_tvalid,
    input  logic [W_IN-1:0]  s_axis_tdata,
    input  logic             m_axis_tready,
    output logic             m_axis_tvalid,
    output logic [W_OUT-1:0] m_axis_tdata,
    output logic             m_axis_tlast
);

    localparam int unsigned N_BEATS = W_IN / W_OUT;
    localparam int unsigned W_CNT   = cnt_width(N_BEATS);
    localparam int unsigned W_OFF   = cnt_width(W_IN);
    localparam logic [W_CNT-1:0] LAST_IDX = W_CNT'(N_BEATS - 1);

    generate
        if (W_IN % W_OUT != 0) begin : g_bad_width
            $error("axis_width_downsizer: W_IN must be an integer multiple of W_OUT");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [W_CNT-1:0] cnt_q, cnt_d;
    logic [W_IN-1:0]  hold_q, hold_d;
    logic             m_valid_q, m_valid_d;

    logic             beat_last;
    logic             s_hs;
    logic             m_hs;
    logic [W_OFF-1:0] beat_off;

    assign beat_last     = (cnt_q == LAST_IDX);
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_valid_q & beat_last;
    assign m_hs          = m_valid_q & m_axis_tready;

    // Ready never looks at s_axis_tvalid, keeping the handshake free of comb loops
    assign s_axis_tready = (state_q == IDLE) | (m_hs & beat_last);
    assign s_hs          = s_axis_tvalid & s_axis_tready;

    // Both orderings reduce to an ascending part-select of the hold register
    always_comb begin
        if (LSB_FIRST) begin
            beat_off = W_OFF'(32'(cnt_q) * W_OUT);
        end else begin
            beat_off = W_OFF'(W_IN - W_OUT * (32'(cnt_q) + 32'd1));
        end
        m_axis_tdata = hold_q[beat_off +: W_OUT];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        m_valid_d = m_valid_q;

        if (s_hs) begin
            hold_d    = s_axis_tdata;
            cnt_d     = '0;
            state_d   = SEND;
            m_valid_d = 1'b1;
        end else if (m_hs) begin
            if (beat_last) begin
                cnt_d     = '0;
                state_d   = IDLE;
                m_valid_d = 1'b0;
            end else begin
                cnt_d = cnt_q + W_CNT'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            m_valid_q <= m_valid_d;
        end
    end

endmodule
